serial_ripple_borrow_subtractor: RTL and testbench
==================================================

// Module: serial_ripple_borrow_subtractor
// PURPOSE
//  Multi-cycle unsigned/two's-complement subtractor: D = A - B - Bin.
//  Inverse of the ripple-carry adder. Processes DIGIT bits per clock, LSB first.
//  The borrow ripples through a registered stage between digits.
//  Sits in the arithmetic datapath where area beats latency.
//  Uses valid/ready handshakes on the operand side and on the result side.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; WIDTH >= 2
//  DIGIT  1  bits processed per cycle; must divide WIDTH (elaboration error otherwise)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      operands A, B and Bin are valid
//  in_ready   out  1      block accepts operands (high only in IDLE)
//  A          in   WIDTH  minuend
//  B          in   WIDTH  subtrahend
//  Bin        in   1      borrow-in
//  out_valid  out  1      D, Bout (and OVF) are valid (high only in DONE)
//  out_ready  in   1      consumer takes the result
//  D          out  WIDTH  difference, modulo 2^WIDTH
//  Bout       out  1      borrow-out; 1 iff A < B + Bin (unsigned)
//  OVF        out  1      signed overflow (only with SUB_OVERFLOW_EN)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   state=IDLE; D=0; Bout=0; OVF=0; out_valid=0; in_ready=1.
//   Reset wins over all other inputs, in any state, mid-operation included.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1.
//    On an edge with in_valid=1: latch A and B into shift registers, borrow<=Bin,
//    digit count<=0, D<=0, go to RUN.
//   RUN: in_ready=0, out_valid=0.
//    Each edge: take the low DIGIT bits of A/B, compute {b,d} = a - b - borrow
//    (ripple-borrow chain of full subtractors), shift d into D from the MSB end,
//    borrow<=b, shift A/B right by DIGIT, increment count.
//    On the edge that processes digit WIDTH/DIGIT-1: Bout<=final borrow, go to DONE.
//   DONE: out_valid=1. D, Bout and OVF are held stable while out_ready=0.
//    On an edge with out_ready=1: go to IDLE.
//    No new operand is accepted on that same edge (in_ready was 0).
//  Latency: out_valid rises WIDTH/DIGIT edges after the accepting edge.
//   Minimum issue interval = WIDTH/DIGIT + 2 cycles.
//  Boundaries:
//   - in_valid is ignored outside IDLE.
//   - A and B may change after acceptance without affecting the result.
//   - Bin=1 with A=B gives D=all-ones, Bout=1.
//   - Operand inputs are sampled only on the accepting edge.
//  Arithmetic is exact modulo 2^WIDTH. Signed interpretation uses D and OVF, not Bout.
// CONFIGURATION
//  SUB_OVERFLOW_EN defined:
//   OVF port exists.
//   OVF <= (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), using the latched MSBs.
//   Updated on the same edge as Bout; reset to 0.
//  SUB_OVERFLOW_EN undefined:
//   OVF port and its logic are absent. All other behaviour is identical.
// TESTING (WIDTH=8 unless noted)
//  1. A=0x05, B=0x03, Bin=0, out_ready=1
//     -> out_valid 8 cycles after accept; D=0x02, Bout=0.
//  2. A=0x00, B=0x01, Bin=0 -> D=0xFF, Bout=1.
//     A=0x10, B=0x10, Bin=1 -> D=0xFF, Bout=1.
//  3. SUB_OVERFLOW_EN: A=0x80, B=0x01 -> D=0x7F, OVF=1, Bout=0.
//     A=0x7F, B=0x01 -> D=0x7E, OVF=0.
//  4. out_ready=0 for 5 cycles in DONE
//     -> D/Bout/out_valid stable, in_ready=0, in_valid pulses ignored;
//     release -> IDLE next cycle.
//  5. rst_n=0 at the 3rd RUN cycle
//     -> next cycle out_valid=0, in_ready=1, D=0;
//     a new op A=0x09, B=0x04 -> D=0x05.
//  6. DIGIT=4: A=0xA3, B=0x5C, Bin=0
//     -> out_valid 2 cycles after accept; D=0x47, Bout=0.
//     Back-to-back random ops checked against a reference model.

Source files
------------

// File: rtl/serial_ripple_borrow_subtractor_if.sv
// Operand/result bundle for the serial subtractor: valid/ready on both sides.
// Latency: none, wires only.
// Backpressure: in_ready gates operands, out_ready gates results. OVF exists only with SUB_OVERFLOW_EN.
interface serial_ripple_borrow_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
`ifdef SUB_OVERFLOW_EN
    logic             OVF;
`endif

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, Bout
`ifdef SUB_OVERFLOW_EN
        , input OVF
`endif
    );

    // The subtractor itself.
    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, Bout
`ifdef SUB_OVERFLOW_EN
        , output OVF
`endif
    );
endinterface

// File: rtl/serial_ripple_borrow_subtractor.sv
// Digit-serial subtractor D = A - B - Bin, DIGIT bits per clock, LSB first; optional OVF via SUB_OVERFLOW_EN.
// Latency: out_valid rises WIDTH/DIGIT edges after the accepting edge; issue interval WIDTH/DIGIT + 2.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module serial_ripple_borrow_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    serial_ripple_borrow_subtractor_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Reject illegal configurations at elaboration.
    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_ripple_borrow_subtractor: DIGIT must divide WIDTH and WIDTH >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] res_q,       res_d;
    logic             borrow_q,    borrow_d;
    logic             bout_q,      bout_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef SUB_OVERFLOW_EN
    logic             a_msb_q,     a_msb_d;
    logic             b_msb_q,     b_msb_d;
    logic             ovf_q,       ovf_d;
`endif

    logic [DIGIT-1:0] dig_diff;
    logic             dig_borrow;
    logic [WIDTH-1:0] res_shift;

    // One digit of full subtractors; borrow ripples from bit 0 upward within the digit.
    always_comb begin
        logic bw;
        bw       = borrow_q;
        dig_diff = '0;
        for (int i = 0; i < DIGIT; i++) begin
            dig_diff[i] = a_q[i] ^ b_q[i] ^ bw;
            bw          = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & bw);
        end
        dig_borrow = bw;
        // New digit enters at the MSB end so the LSB-first digits land in place after NDIG steps.
        res_shift  = (res_q >> DIGIT) | (WIDTH'(dig_diff) << (WIDTH - DIGIT));
    end

    // Next-state and datapath update; everything holds unless the state says otherwise.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        borrow_d    = borrow_q;
        bout_d      = bout_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SUB_OVERFLOW_EN
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d        = bus.A;
                    b_d        = bus.B;
                    borrow_d   = bus.Bin;
                    cnt_d      = '0;
                    res_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
`ifdef SUB_OVERFLOW_EN
                    a_msb_d    = bus.A[WIDTH-1];
                    b_msb_d    = bus.B[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                res_d    = res_shift;
                borrow_d = dig_borrow;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    bout_d      = dig_borrow;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef SUB_OVERFLOW_EN
                    // Operand signs differ and the result sign flipped away from A's.
                    ovf_d       = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            borrow_q    <= borrow_d;
            bout_q      <= bout_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SUB_OVERFLOW_EN
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.D         = res_q;
    assign bus.Bout      = bout_q;
`ifdef SUB_OVERFLOW_EN
    assign bus.OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_ripple_borrow_subtractor.sv
// Bench for serial_ripple_borrow_subtractor: DIGIT=1 and DIGIT=4 instances, WIDTH=8.
// Latency: checks WIDTH/DIGIT edges from accept to out_valid.
// Backpressure: exercises out_ready stalls, ignored in_valid, and mid-run reset.
module tb_serial_ripple_borrow_subtractor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;          // 0: DIGIT=1 instance, 1: DIGIT=4 instance
    logic       in_valid;
    logic [7:0] A, B;
    logic       Bin;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_ripple_borrow_subtractor_if #(.WIDTH(8)) b8 ();
    serial_ripple_borrow_subtractor_if #(.WIDTH(8)) b4 ();

    assign b8.in_valid  = in_valid & ~sel;
    assign b4.in_valid  = in_valid & sel;
    assign b8.A         = A;
    assign b4.A         = A;
    assign b8.B         = B;
    assign b4.B         = B;
    assign b8.Bin       = Bin;
    assign b4.Bin       = Bin;
    assign b8.out_ready = out_ready;
    assign b4.out_ready = out_ready;

    serial_ripple_borrow_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );
    serial_ripple_borrow_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    wire       ov = sel ? b4.out_valid : b8.out_valid;
    wire       ir = sel ? b4.in_ready  : b8.in_ready;
    wire [7:0] dm = sel ? b4.D         : b8.D;
    wire       bm = sel ? b4.Bout      : b8.Bout;
`ifdef SUB_OVERFLOW_EN
    wire       om = sel ? b4.OVF       : b8.OVF;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // One full transaction on the selected instance with out_ready held high.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] ed, input logic eb, input logic eo, input string tag);
        int lat;
        int exp_lat;
        exp_lat = sel ? 2 : 8;
        @(negedge clk);
        A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, " in_ready before accept"}, 32'(ir), 32'd1);
        @(negedge clk);
        // Scramble operands after acceptance; result must not care.
        in_valid = 1'b0; A = ~a; B = 8'($urandom); Bin = ~bin;
        lat = 0;
        while (!ov && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " D"}, 32'(dm), 32'(ed));
        chk({tag, " Bout"}, 32'(bm), 32'(eb));
`ifdef SUB_OVERFLOW_EN
        chk({tag, " OVF"}, 32'(om), 32'(eo));
`else
        if (eo === 1'bz) $display("note: %s ovf reference undefined", tag);
`endif
        @(negedge clk);
        chk({tag, " out_valid after take"}, 32'(ov), 32'd0);
        chk({tag, " in_ready after take"}, 32'(ir), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb, rd;
        logic       rbin, rbout, rovf;
        logic [8:0] sub9;

        vt[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vt[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vt[4] = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0};
        vt[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vt[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[8] = '{8'h3C, 8'hC3, 1'b1, 8'h78, 1'b1, 1'b0};
        vt[9] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};

        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0;
        A = 8'h00; B = 8'h00; Bin = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset in_ready d1",  32'(b8.in_ready),  32'd1);
        chk("reset out_valid d1", 32'(b8.out_valid), 32'd0);
        chk("reset D d1",         32'(b8.D),         32'd0);
        chk("reset Bout d1",      32'(b8.Bout),      32'd0);
        chk("reset in_ready d4",  32'(b4.in_ready),  32'd1);
        chk("reset out_valid d4", 32'(b4.out_valid), 32'd0);
        rst_n = 1'b1;

        // Directed table on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 10; i++)
                run_op(vt[i].a, vt[i].b, vt[i].bin, vt[i].d, vt[i].bout, vt[i].ovf,
                       $sformatf("vec%0d dig%0d", i, s ? 4 : 1));
        end
        sel = 1'b1;
        run_op(8'hA3, 8'h5C, 1'b0, 8'h47, 1'b0, 1'b0, "dig4 A3-5C");

        // Result held under backpressure; in_valid ignored while busy.
        sel = 1'b0;
        @(negedge clk);
        A = 8'h00; B = 8'h01; Bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        begin
            int w;
            w = 0;
            while (!ov && w < 40) begin
                @(negedge clk);
                w++;
            end
            chk("stall latency", 32'(w), 32'd8);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d out_valid", c), 32'(ov), 32'd1);
            chk($sformatf("stall%0d in_ready", c),  32'(ir), 32'd0);
            chk($sformatf("stall%0d D", c),         32'(dm), 32'hFF);
            chk($sformatf("stall%0d Bout", c),      32'(bm), 32'd1);
            in_valid = c[0]; A = 8'h55; B = 8'h11;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("release out_valid", 32'(ov), 32'd0);
        chk("release in_ready",  32'(ir), 32'd1);
        @(negedge clk);
        chk("no stray accept", 32'(ir), 32'd1);

        // Reset during the third RUN edge.
        @(negedge clk);
        A = 8'hFF; B = 8'h00; Bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrun partial D", 32'(dm), 32'hC0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun rst out_valid", 32'(ov), 32'd0);
        chk("midrun rst in_ready",  32'(ir), 32'd1);
        chk("midrun rst D",         32'(dm), 32'd0);
        chk("midrun rst Bout",      32'(bm), 32'd0);
        rst_n = 1'b1;
        run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, "post reset 09-04");

        // Random operations against a reference model, both instances.
        for (int s = 0; s < 2; s++) begin
            sel = ~s[0];
            for (int k = 0; k < 12; k++) begin
                ra    = 8'($urandom);
                rb    = 8'($urandom);
                rbin  = 1'($urandom);
                sub9  = {1'b0, ra} - {1'b0, rb} - {8'h00, rbin};
                rd    = sub9[7:0];
                rbout = ({1'b0, ra} < ({1'b0, rb} + {8'h00, rbin}));
                rovf  = (ra[7] != rb[7]) && (rd[7] != ra[7]);
                run_op(ra, rb, rbin, rd, rbout, rovf, $sformatf("rand%0d dig%0d", k, sel ? 4 : 1));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
